// File: rtl/shift_register_piso_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on a valid/ready
// handshake and shifts it out MSB first. Define PISO_TX_PARITY_EN for a trailing even-parity bit.
module shift_register_piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             handshake;

`ifdef PISO_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // Ready in the last-bit cycle lets a new frame follow with no gap.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign din_ready = !rst && ((state_q == IDLE) || last_bit);
  assign handshake = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (handshake) begin
      state_d = SHIFT;
      shreg_d = din;
      cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
      parity_d = ^din;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (last_bit) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
            parity_d = 1'b0;
`endif
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs decode flops only; the parity bit follows the LSB when enabled.
  always_comb begin
    so = 1'b0;
    if (state_q == SHIFT) begin
`ifdef PISO_TX_PARITY_EN
      so = (cnt_q == CW'(WIDTH)) ? parity_q : shreg_q[WIDTH-1];
`else
      so = shreg_q[WIDTH-1];
`endif
    end
  end

  assign so_valid = (state_q == SHIFT);
  assign busy     = so_valid;
  assign done     = last_bit;

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Self-checking bench for shift_register_piso_tx (WIDTH=8): directed table,
// hand-written corner sequences and random traffic against a bit-queue model.
module tb_shift_register_piso_tx;

  localparam int WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready, so, so_valid, busy, done;

  shift_register_piso_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .so        (so),
    .so_valid  (so_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: queue of bits still to appear on so, each tagged with whether it ends a frame.
  typedef struct packed {
    logic b;
    logic last;
  } mbit_t;
  mbit_t model_q[$];

  typedef struct {
    logic             r;
    logic             v;
    logic [WIDTH-1:0] d;
    logic             e_so;
    logic             e_sv;
    logic             e_done;
    logic             e_rdy;
  } vec_t;
  vec_t vecs[0:15];
  int   nvec;

  logic o_so, o_sv, o_done, o_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic model_ready(input logic r);
    return !r && ((model_q.size() == 0) || model_q[0].last);
  endfunction

  task automatic model_push(input logic [WIDTH-1:0] d);
    mbit_t m;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      m.b    = d[i];
      m.last = (FRAME_LEN == WIDTH) && (i == 0);
      model_q.push_back(m);
    end
    if (FRAME_LEN != WIDTH) begin
      m.b    = ^d;
      m.last = 1'b1;
      model_q.push_back(m);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d);
    logic e_sv, e_so, e_done, e_rdy, hs;
    @(negedge clk);
    rst = r; din_valid = v; din = d;
    #1;
    e_sv   = (model_q.size() != 0);
    e_so   = e_sv ? model_q[0].b : 1'b0;
    e_done = e_sv ? model_q[0].last : 1'b0;
    e_rdy  = model_ready(r);
    o_so = so; o_sv = so_valid; o_done = done; o_rdy = din_ready;
    chk("model_so", so, e_so);
    chk("model_so_valid", so_valid, e_sv);
    chk("model_busy", busy, e_sv);
    chk("model_done", done, e_done);
    chk("model_din_ready", din_ready, e_rdy);
    hs = v && e_rdy;
    if (hs) $display("tx handshake din=%02h t=%0t", d, $time);
    @(posedge clk);
    if (r) model_q.delete();
    else begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      if (hs) model_push(d);
    end
  endtask

  int sv_run, done_cnt;
  logic [7:0] a5;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0;
    repeat (2) @(posedge clk);

    // Reset state, including din_ready low while rst is held.
    cycle(1'b1, 1'b0, '0);
    chk("reset_so_valid", o_sv, 1'b0);
    chk("reset_ready_in_rst", o_rdy, 1'b0);
    cycle(1'b0, 1'b0, '0);
    chk("ready_after_release", o_rdy, 1'b1);

    // Directed table: single 0xA5 frame.
    a5 = 8'hA5;
    vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k <= FRAME_LEN; k++) begin
      vecs[k].r = 1'b0; vecs[k].v = 1'b0; vecs[k].d = 8'h3C;
      vecs[k].e_so   = (k <= WIDTH) ? a5[WIDTH-k] : 1'b0;
      vecs[k].e_sv   = 1'b1;
      vecs[k].e_done = (k == FRAME_LEN);
      vecs[k].e_rdy  = (k == FRAME_LEN);
    end
    vecs[FRAME_LEN+1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    nvec = FRAME_LEN + 2;
    for (int i = 0; i < nvec; i++) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].d);
      chk($sformatf("tbl%0d_so", i), o_so, vecs[i].e_so);
      chk($sformatf("tbl%0d_sv", i), o_sv, vecs[i].e_sv);
      chk($sformatf("tbl%0d_done", i), o_done, vecs[i].e_done);
      chk($sformatf("tbl%0d_rdy", i), o_rdy, vecs[i].e_rdy);
    end

    // Back-to-back: 0xFF then 0x00 with valid held -> two contiguous frames.
    cycle(1'b0, 1'b1, 8'hFF);
    sv_run = 0; done_cnt = 0;
    for (int k = 0; k < 2 * FRAME_LEN + 2; k++) begin
      cycle(1'b0, 1'b1 && (k < FRAME_LEN), 8'h00);
      if (o_sv) sv_run++;
      if (o_done) done_cnt++;
    end
    chk("b2b_valid_cycles", sv_run, 2 * FRAME_LEN);
    chk("b2b_done_count", done_cnt, 2);

    // Valid pulsed mid-frame while not ready is ignored.
    cycle(1'b0, 1'b1, 8'hA5);
    for (int k = 1; k <= FRAME_LEN; k++) begin
      cycle(1'b0, (k == 3), 8'h3C);
      if (k <= WIDTH) chk($sformatf("ign_bit%0d", k), o_so, a5[WIDTH-k]);
      if (k < FRAME_LEN) chk($sformatf("ign_rdy%0d", k), o_rdy, 1'b0);
    end
    cycle(1'b0, 1'b0, '0);
    chk("ign_idle_after", o_sv, 1'b0);

    // Reset mid-frame aborts without done.
    cycle(1'b0, 1'b1, 8'hA5);
    for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    chk("abort_so", o_so, 1'b0);
    chk("abort_sv", o_sv, 1'b0);
    chk("abort_done", o_done, 1'b0);
    chk("abort_rdy", o_rdy, 1'b1);

    // Reset beats a simultaneous handshake.
    cycle(1'b1, 1'b1, 8'h81);
    cycle(1'b0, 1'b0, '0);
    chk("rst_hs_sv", o_sv, 1'b0);
    cycle(1'b0, 1'b0, '0);
    chk("rst_hs_sv2", o_sv, 1'b0);

`ifdef PISO_TX_PARITY_EN
    // Parity bit for 0x07 is 1, on the cycle carrying done.
    cycle(1'b0, 1'b1, 8'h07);
    for (int k = 1; k <= FRAME_LEN; k++) cycle(1'b0, 1'b0, '0);
    chk("par07_bit", o_so, 1'b1);
    chk("par07_done", o_done, 1'b1);
    cycle(1'b0, 1'b0, '0);
`endif

    // Random traffic, including occasional reset.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), WIDTH'($urandom));
    end
    for (int n = 0; n < FRAME_LEN + 2; n++) cycle(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
